// File: rtl/aqrv_bus_pkg.sv
// Shared types and constants for the aqrv bus DMA engine.
package aqrv_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_RGAP = 3'd2,
        ST_WR   = 3'd3,
        ST_WGAP = 3'd4,
        ST_DONE = 3'd5
    } dma_state_t;

    localparam logic [3:0] STB_READ  = 4'h0;
    localparam logic [3:0] STB_WRITE = 4'hF;

    // Width of the bus wait counter; it saturates instead of wrapping.
    localparam int WDT_W = 32;

    // Force a byte address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/aqrv_bus_wdt.sv
// Bus wait watchdog: counts stalled request cycles and flags expiry on the
// cycle whose stall brings the count up to the limit.
module aqrv_bus_wdt
    import aqrv_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall,
    input  logic clear,
    output logic expire
);

    localparam logic [WDT_W-1:0] LIMIT = TIMEOUT_CYCLES[WDT_W-1:0];

    logic [WDT_W-1:0] cnt;
    logic [WDT_W-1:0] cnt_inc;

    // Saturating increment so a long stall never wraps back to zero.
    always_comb begin
        cnt_inc = (cnt == {WDT_W{1'b1}}) ? cnt : cnt + 1'b1;
    end

    // Wait counter register; cleared whenever the request is idle or acknowledged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (stall) begin
            cnt <= cnt_inc;
        end
    end

    assign expire = (LIMIT != '0) && stall && (cnt_inc == LIMIT);

endmodule

// File: rtl/aqrv_bus_dma.sv
// Single-channel word copy engine on a simple valid/ready local bus.
// Each word costs RD, RGAP, WR, WGAP; stalled requests are bounded by a watchdog.
module aqrv_bus_dma
    import aqrv_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        CMD_VALID,
    output logic        CMD_READY,
    input  logic [31:0] CMD_SRC,
    input  logic [31:0] CMD_DST,
    input  logic [15:0] CMD_LEN,
    input  logic        ABORT,
    output logic        BUS_VALID,
    input  logic        BUS_READY,
    output logic [3:0]  BUS_WSTB,
    output logic [31:0] BUS_ADDR,
    output logic [31:0] BUS_WDATA,
    input  logic [31:0] BUS_RDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [15:0] XFER_CNT
);

    dma_state_t  state;
    dma_state_t  state_nxt;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    logic [31:0] data;
    logic [15:0] xfer_cnt;
    logic        err;
    logic        abort_q;
    logic        accept;
    logic        abort_hit;
    logic        expire;
    logic        rd_ack;
    logic        wr_ack;

    assign accept    = CMD_VALID && (state == ST_IDLE);
    assign abort_hit = abort_q || ABORT;
    // READY only counts while a request is actually on the bus.
    assign rd_ack    = (state == ST_RD) && BUS_READY;
    assign wr_ack    = (state == ST_WR) && BUS_READY;

    aqrv_bus_wdt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wdt (
        .clk    (CLK),
        .rst_n  (RST_N),
        .stall  (BUS_VALID && !BUS_READY),
        .clear  (!BUS_VALID || BUS_READY),
        .expire (expire)
    );

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort is only honoured in the gap states.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (CMD_VALID) begin
                    state_nxt = (CMD_LEN == 16'd0) ? ST_DONE : ST_RD;
                end
            end
            ST_RD: begin
                if (expire)         state_nxt = ST_DONE;
                else if (BUS_READY) state_nxt = ST_RGAP;
            end
            ST_RGAP: begin
                state_nxt = abort_hit ? ST_DONE : ST_WR;
            end
            ST_WR: begin
                if (expire)         state_nxt = ST_DONE;
                else if (BUS_READY) state_nxt = ST_WGAP;
            end
            ST_WGAP: begin
                if (xfer_cnt == len || abort_hit) state_nxt = ST_DONE;
                else                              state_nxt = ST_RD;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: command latch, read capture, address/count advance, sticky flags.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            src      <= '0;
            dst      <= '0;
            len      <= '0;
            data     <= '0;
            xfer_cnt <= '0;
            err      <= 1'b0;
            abort_q  <= 1'b0;
        end else if (accept) begin
            src      <= word_align(CMD_SRC);
            dst      <= word_align(CMD_DST);
            len      <= CMD_LEN;
            xfer_cnt <= '0;
            err      <= 1'b0;
            abort_q  <= 1'b0;
        end else begin
            if (state != ST_IDLE && ABORT) begin
                abort_q <= 1'b1;
            end
            if (rd_ack) begin
                data <= BUS_RDATA;
            end
            if (wr_ack) begin
                xfer_cnt <= xfer_cnt + 16'd1;
                src      <= src + 32'd4;
                dst      <= dst + 32'd4;
            end
            if (expire) begin
                err <= 1'b1;
            end
        end
    end

    // Outputs decoded from state; bus fields are zero outside request states.
    always_comb begin
        CMD_READY = (state == ST_IDLE);
        BUSY      = (state != ST_IDLE);
        DONE      = (state == ST_DONE);
        BUS_VALID = 1'b0;
        BUS_WSTB  = STB_READ;
        BUS_ADDR  = '0;
        BUS_WDATA = '0;
        case (state)
            ST_RD: begin
                BUS_VALID = 1'b1;
                BUS_WSTB  = STB_READ;
                BUS_ADDR  = src;
            end
            ST_WR: begin
                BUS_VALID = 1'b1;
                BUS_WSTB  = STB_WRITE;
                BUS_ADDR  = dst;
                BUS_WDATA = data;
            end
            default: begin
            end
        endcase
    end

    assign ERR      = err;
    assign XFER_CNT = xfer_cnt;

endmodule

// File: tb/tb_aqrv_bus_dma.sv
// Directed bench for aqrv_bus_dma with switchable responder models.
module tb_aqrv_bus_dma;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_src = '0;
    logic [31:0] cmd_dst = '0;
    logic [15:0] cmd_len = '0;
    logic        abort = 1'b0;
    logic        bus_valid;
    logic        bus_ready;
    logic [3:0]  bus_wstb;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] xfer_cnt;

    // Responder modes: 0 zero-wait memory, 1 GPIO with registered ready,
    // 2 never ready, 3 reads ready / writes never ready.
    int          mode = 0;
    logic [31:0] gpio_i = 32'hA5A5_A5A5;
    logic [31:0] gpio_o = '0;
    logic        gpio_rdy_q = 1'b0;

    logic [31:0] rd_addr_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          valid_cnt = 0;
    int          done_cnt = 0;

    int errors = 0;
    int checks = 0;
    int cyc;

    always #5 clk = ~clk;

    aqrv_bus_dma #(.TIMEOUT_CYCLES(8)) dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .CMD_VALID (cmd_valid),
        .CMD_READY (cmd_ready),
        .CMD_SRC   (cmd_src),
        .CMD_DST   (cmd_dst),
        .CMD_LEN   (cmd_len),
        .ABORT     (abort),
        .BUS_VALID (bus_valid),
        .BUS_READY (bus_ready),
        .BUS_WSTB  (bus_wstb),
        .BUS_ADDR  (bus_addr),
        .BUS_WDATA (bus_wdata),
        .BUS_RDATA (bus_rdata),
        .BUSY      (busy),
        .DONE      (done),
        .ERR       (err),
        .XFER_CNT  (xfer_cnt)
    );

    // Responder: ready and read data per mode. Memory read data is {A5, addr[23:0]}.
    always_comb begin
        case (mode)
            0:       bus_ready = 1'b1;
            1:       bus_ready = gpio_rdy_q;
            2:       bus_ready = 1'b0;
            default: bus_ready = (bus_wstb == 4'h0);
        endcase
        if (mode == 1) bus_rdata = (bus_addr == 32'h0) ? gpio_i : 32'h0;
        else           bus_rdata = {8'hA5, bus_addr[23:0]};
    end

    // Bus monitor and GPIO output register.
    always @(posedge clk) begin
        gpio_rdy_q <= bus_valid;
        if (done) done_cnt++;
        if (bus_valid) valid_cnt++;
        if (bus_valid && bus_ready) begin
            if (bus_wstb == 4'h0) begin
                rd_addr_q.push_back(bus_addr);
            end else begin
                wr_addr_q.push_back(bus_addr);
                wr_data_q.push_back(bus_wdata);
                if (mode == 1 && bus_addr == 32'h4) gpio_o <= bus_wdata;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        rd_addr_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        valid_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic issue(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        @(negedge clk);
        chk("cmd_ready_before", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_src = s;
        cmd_dst = d;
        cmd_len = l;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    // Counts cycles between accept and the DONE pulse; checks pulse width.
    task automatic wait_done(output int n);
        bit got;
        got = 1'b0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                break;
            end
            n++;
        end
        chk("done_seen", {31'd0, got}, 32'd1);
        @(negedge clk);
        chk("done_one_cycle", {31'd0, done}, 32'd0);
        chk("idle_after_done", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic wait_wr(output bit got);
        got = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus_valid && bus_wstb == 4'hF) begin
                got = 1'b1;
                break;
            end
        end
        chk("wr_phase_seen", {31'd0, got}, 32'd1);
    endtask

    initial begin
        bit got;

        // Reset values
        #2;
        chk("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_xfer_cnt", {16'd0, xfer_cnt}, 32'd0);
        chk("rst_addr", bus_addr, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);

        // Three-word copy, zero-wait memory
        mode = 0;
        clear_mon();
        issue(32'h100, 32'h200, 16'd3);
        wait_done(cyc);
        chk("copy_cycles", cyc, 32'd12);
        chk("copy_rd_n", rd_addr_q.size(), 32'd3);
        chk("copy_wr_n", wr_addr_q.size(), 32'd3);
        chk("copy_rd0", rd_addr_q[0], 32'h100);
        chk("copy_rd1", rd_addr_q[1], 32'h104);
        chk("copy_rd2", rd_addr_q[2], 32'h108);
        chk("copy_wr0", wr_addr_q[0], 32'h200);
        chk("copy_wr1", wr_addr_q[1], 32'h204);
        chk("copy_wr2", wr_addr_q[2], 32'h208);
        chk("copy_wd0", wr_data_q[0], 32'hA500_0100);
        chk("copy_wd1", wr_data_q[1], 32'hA500_0104);
        chk("copy_wd2", wr_data_q[2], 32'hA500_0108);
        chk("copy_xfer", {16'd0, xfer_cnt}, 32'd3);
        chk("copy_err", {31'd0, err}, 32'd0);
        chk("copy_done_cnt", done_cnt, 32'd1);

        // GPIO responder with trailing ready in the gap cycles
        mode = 1;
        clear_mon();
        issue(32'h0, 32'h4, 16'd1);
        wait_done(cyc);
        chk("gpio_out", gpio_o, 32'hA5A5_A5A5);
        chk("gpio_cycles", cyc, 32'd6);
        chk("gpio_rd_n", rd_addr_q.size(), 32'd1);
        chk("gpio_wr_n", wr_addr_q.size(), 32'd1);
        chk("gpio_xfer", {16'd0, xfer_cnt}, 32'd1);

        // Zero-length command
        mode = 0;
        clear_mon();
        issue(32'h100, 32'h200, 16'd0);
        wait_done(cyc);
        chk("len0_cycles", cyc, 32'd0);
        chk("len0_valid_cnt", valid_cnt, 32'd0);
        chk("len0_xfer", {16'd0, xfer_cnt}, 32'd0);

        // Timeout against a responder that never acknowledges
        mode = 2;
        clear_mon();
        issue(32'h10, 32'h20, 16'd2);
        wait_done(cyc);
        chk("to_valid_cnt", valid_cnt, 32'd8);
        chk("to_cycles", cyc, 32'd8);
        chk("to_err", {31'd0, err}, 32'd1);
        chk("to_xfer", {16'd0, xfer_cnt}, 32'd0);
        chk("to_err_sticky", {31'd0, err}, 32'd1);

        // Source wrap at the top of the address space, unaligned destination
        mode = 0;
        clear_mon();
        issue(32'hFFFF_FFFC, 32'h302, 16'd2);
        wait_done(cyc);
        chk("wrap_rd1", rd_addr_q[1], 32'h0);
        chk("wrap_wr0", wr_addr_q[0], 32'h300);
        chk("wrap_wd0", wr_data_q[0], 32'hA5FF_FFFC);
        chk("wrap_wd1", wr_data_q[1], 32'hA500_0000);
        chk("wrap_xfer", {16'd0, xfer_cnt}, 32'd2);
        chk("wrap_err_cleared", {31'd0, err}, 32'd0);

        // Abort raised during the first write
        clear_mon();
        issue(32'hFFFF_FFFC, 32'h300, 16'd2);
        wait_wr(got);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done(cyc);
        chk("abort_rd_n", rd_addr_q.size(), 32'd1);
        chk("abort_wr_n", wr_addr_q.size(), 32'd1);
        chk("abort_xfer", {16'd0, xfer_cnt}, 32'd1);
        chk("abort_err", {31'd0, err}, 32'd0);

        // Reset in the middle of a stalled write
        mode = 3;
        clear_mon();
        issue(32'h100, 32'h200, 16'd1);
        wait_wr(got);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, bus_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_xfer", {16'd0, xfer_cnt}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("midrst_no_done", done_cnt, 32'd0);

        mode = 0;
        clear_mon();
        issue(32'h100, 32'h240, 16'd1);
        wait_done(cyc);
        chk("post_rst_wr", wr_addr_q[0], 32'h240);
        chk("post_rst_wd", wr_data_q[0], 32'hA500_0100);
        chk("post_rst_xfer", {16'd0, xfer_cnt}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
